// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller for a five-stage pipeline. It forwards the EX/MEM
// data request to the cache, stalls the front of the pipeline until the cache
// answers, loads the MEM/WB pipeline register, freezes on halt, and counts
// stalled cycles.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   *_EX_MEM             EX/MEM pipeline register contents
//   dhit, dmemload       cache completion strobe and read data
//   flush_MEM_WB         load a bubble into MEM/WB
//   dREN, dWEN           cache read/write request (write wins if both set)
//   daddr, dstore        cache request address and store data
//   mem_stall            hold EX/MEM and earlier stages
//   *_MEM_WB, wsel_MEM_WB  MEM/WB pipeline register outputs
//   stall_cycles         saturating count of stalled cycles
module mem_stage_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        WEN_EX_MEM,
  input  logic        dmemREN_EX_MEM,
  input  logic        dmemWEN_EX_MEM,
  input  logic        halt_EX_MEM,
  input  logic [31:0] dmemaddr_EX_MEM,
  input  logic [31:0] dmemstore_EX_MEM,
  input  logic [31:0] result_EX_MEM,
  input  logic [1:0]  reg_dest_EX_MEM,
  input  logic [4:0]  Rt_EX_MEM,
  input  logic [4:0]  Rd_EX_MEM,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        flush_MEM_WB,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        mem_stall,
  output logic        WEN_MEM_WB,
  output logic        halt_MEM_WB,
  output logic [31:0] result_MEM_WB,
  output logic [31:0] dmemload_MEM_WB,
  output logic [4:0]  wsel_MEM_WB,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_req;
  logic        w_stall;
  logic        w_advance;
  logic [4:0]  w_wsel;

  logic        r_wen;
  logic        r_halt;
  logic [31:0] r_result;
  logic [31:0] r_load;
  logic [4:0]  r_wsel;
  logic [31:0] r_stallCycles;

  assign w_req  = dmemREN_EX_MEM | dmemWEN_EX_MEM;
  assign daddr  = dmemaddr_EX_MEM;
  assign dstore = dmemstore_EX_MEM;

  // A cycle with no stall moves the EX/MEM contents on, unless we are halted.
  assign w_advance = ~w_stall & (r_state != HALTED);

  // Destination code 3 aliases Rd.
  always_comb begin
    case (reg_dest_EX_MEM)
      2'd0:    w_wsel = Rt_EX_MEM;
      2'd2:    w_wsel = 5'd31;
      default: w_wsel = Rd_EX_MEM;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next state and cache request. A dhit without a request is ignored because
  // the stall term is gated by w_req. Halt only takes effect on a cycle that
  // actually advances, so a pending access finishes before HALTED.
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    case (r_state)
      IDLE, WAIT: begin
        dWEN = dmemWEN_EX_MEM;
        dREN = dmemREN_EX_MEM & ~dmemWEN_EX_MEM;
        if (w_req && !dhit) begin
          w_stall     = 1'b1;
          w_nextState = WAIT;
        end else if (halt_EX_MEM) begin
          w_nextState = HALTED;
        end else begin
          w_nextState = IDLE;
        end
      end
      HALTED: w_nextState = HALTED;
      default: w_nextState = IDLE;
    endcase
  end

  assign mem_stall = w_stall;

  // MEM/WB register: frozen once halted, bubble on stall or flush, otherwise
  // captures the advancing instruction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wen    <= 1'b0;
      r_halt   <= 1'b0;
      r_result <= '0;
      r_load   <= '0;
      r_wsel   <= '0;
    end else if (r_state == HALTED) begin
      r_wen    <= r_wen;
    end else if (flush_MEM_WB || !w_advance) begin
      r_wen    <= 1'b0;
      r_halt   <= 1'b0;
      r_result <= '0;
      r_load   <= '0;
      r_wsel   <= '0;
    end else begin
      r_wen    <= WEN_EX_MEM;
      r_halt   <= halt_EX_MEM;
      r_result <= result_EX_MEM;
      r_load   <= dmemREN_EX_MEM ? dmemload : 32'd0;
      r_wsel   <= w_wsel;
    end
  end

  // Stall counter saturates at all ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                 r_stallCycles <= '0;
    else if (w_stall && (r_stallCycles != '1)) r_stallCycles <= r_stallCycles + 32'd1;
  end

  assign WEN_MEM_WB      = r_wen;
  assign halt_MEM_WB     = r_halt;
  assign result_MEM_WB   = r_result;
  assign dmemload_MEM_WB = r_load;
  assign wsel_MEM_WB     = r_wsel;
  assign stall_cycles    = r_stallCycles;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl: inputs change on the falling edge,
// combinational outputs are checked 1 time unit later, registered outputs
// 1 time unit after the rising edge. Expected values are hand-computed.
module tb_mem_stage_ctrl;

  logic        CLK;
  logic        nRST;
  logic        WEN_EX_MEM;
  logic        dmemREN_EX_MEM;
  logic        dmemWEN_EX_MEM;
  logic        halt_EX_MEM;
  logic [31:0] dmemaddr_EX_MEM;
  logic [31:0] dmemstore_EX_MEM;
  logic [31:0] result_EX_MEM;
  logic [1:0]  reg_dest_EX_MEM;
  logic [4:0]  Rt_EX_MEM;
  logic [4:0]  Rd_EX_MEM;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flush_MEM_WB;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        mem_stall;
  logic        WEN_MEM_WB;
  logic        halt_MEM_WB;
  logic [31:0] result_MEM_WB;
  logic [31:0] dmemload_MEM_WB;
  logic [4:0]  wsel_MEM_WB;
  logic [31:0] stall_cycles;

  int vectors;
  int miscompares;

  mem_stage_ctrl dut (
    .CLK(CLK),
    .nRST(nRST),
    .WEN_EX_MEM(WEN_EX_MEM),
    .dmemREN_EX_MEM(dmemREN_EX_MEM),
    .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
    .halt_EX_MEM(halt_EX_MEM),
    .dmemaddr_EX_MEM(dmemaddr_EX_MEM),
    .dmemstore_EX_MEM(dmemstore_EX_MEM),
    .result_EX_MEM(result_EX_MEM),
    .reg_dest_EX_MEM(reg_dest_EX_MEM),
    .Rt_EX_MEM(Rt_EX_MEM),
    .Rd_EX_MEM(Rd_EX_MEM),
    .dhit(dhit),
    .dmemload(dmemload),
    .flush_MEM_WB(flush_MEM_WB),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .mem_stall(mem_stall),
    .WEN_MEM_WB(WEN_MEM_WB),
    .halt_MEM_WB(halt_MEM_WB),
    .result_MEM_WB(result_MEM_WB),
    .dmemload_MEM_WB(dmemload_MEM_WB),
    .wsel_MEM_WB(wsel_MEM_WB),
    .stall_cycles(stall_cycles)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Returns all EX/MEM and cache inputs to a quiet non-memory op.
  task automatic applyStimulus();
    WEN_EX_MEM       = 1'b0;
    dmemREN_EX_MEM   = 1'b0;
    dmemWEN_EX_MEM   = 1'b0;
    halt_EX_MEM      = 1'b0;
    dmemaddr_EX_MEM  = 32'd0;
    dmemstore_EX_MEM = 32'd0;
    result_EX_MEM    = 32'd0;
    reg_dest_EX_MEM  = 2'd0;
    Rt_EX_MEM        = 5'd0;
    Rd_EX_MEM        = 5'd0;
    dhit             = 1'b0;
    dmemload         = 32'd0;
    flush_MEM_WB     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b0;
    applyStimulus();

    // Reset state, and IDLE request forwarding while reset is held.
    #2;
    checkOutput("rst_wen", {31'd0, WEN_MEM_WB}, 32'd0);
    checkOutput("rst_halt", {31'd0, halt_MEM_WB}, 32'd0);
    checkOutput("rst_result", result_MEM_WB, 32'd0);
    checkOutput("rst_load", dmemload_MEM_WB, 32'd0);
    checkOutput("rst_wsel", {27'd0, wsel_MEM_WB}, 32'd0);
    checkOutput("rst_stallcnt", stall_cycles, 32'd0);
    dmemREN_EX_MEM = 1'b1;
    #1;
    checkOutput("rst_dren", {31'd0, dREN}, 32'd1);
    checkOutput("rst_stall", {31'd0, mem_stall}, 32'd1);
    dmemREN_EX_MEM = 1'b0;

    // Non-memory op with reg_dest=2 writes r31.
    @(negedge CLK);
    nRST = 1'b1;
    result_EX_MEM   = 32'h1234;
    reg_dest_EX_MEM = 2'd2;
    WEN_EX_MEM      = 1'b1;
    #1;
    checkOutput("alu_dren", {31'd0, dREN}, 32'd0);
    checkOutput("alu_dwen", {31'd0, dWEN}, 32'd0);
    checkOutput("alu_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    checkOutput("alu_result", result_MEM_WB, 32'h1234);
    checkOutput("alu_wsel", {27'd0, wsel_MEM_WB}, 32'd31);
    checkOutput("alu_wen", {31'd0, WEN_MEM_WB}, 32'd1);

    // Load with dhit after three stalled cycles.
    @(negedge CLK);
    applyStimulus();
    dmemREN_EX_MEM  = 1'b1;
    dmemaddr_EX_MEM = 32'h100;
    Rt_EX_MEM       = 5'd8;
    reg_dest_EX_MEM = 2'd0;
    WEN_EX_MEM      = 1'b1;
    dmemload        = 32'hDEADBEEF;
    result_EX_MEM   = 32'h100;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      checkOutput("ld_stall", {31'd0, mem_stall}, 32'd1);
      checkOutput("ld_dren", {31'd0, dREN}, 32'd1);
      checkOutput("ld_daddr", daddr, 32'h100);
      @(posedge CLK); #1;
      checkOutput("ld_bubble_wen", {31'd0, WEN_MEM_WB}, 32'd0);
      checkOutput("ld_stallcnt", stall_cycles, 32'(i + 1));
    end
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    checkOutput("ld_hit_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    checkOutput("ld_wen", {31'd0, WEN_MEM_WB}, 32'd1);
    checkOutput("ld_wsel", {27'd0, wsel_MEM_WB}, 32'd8);
    checkOutput("ld_data", dmemload_MEM_WB, 32'hDEADBEEF);
    checkOutput("ld_stallcnt_final", stall_cycles, 32'd3);

    // Store with same-cycle dhit: no stall, no register write.
    @(negedge CLK);
    applyStimulus();
    dmemWEN_EX_MEM   = 1'b1;
    dmemaddr_EX_MEM  = 32'h40;
    dmemstore_EX_MEM = 32'h55;
    dmemload         = 32'hFFFF0000;
    dhit             = 1'b1;
    #1;
    checkOutput("st_dwen", {31'd0, dWEN}, 32'd1);
    checkOutput("st_dren", {31'd0, dREN}, 32'd0);
    checkOutput("st_daddr", daddr, 32'h40);
    checkOutput("st_dstore", dstore, 32'h55);
    checkOutput("st_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    checkOutput("st_wen", {31'd0, WEN_MEM_WB}, 32'd0);
    checkOutput("st_load_zero", dmemload_MEM_WB, 32'd0);
    checkOutput("st_stallcnt", stall_cycles, 32'd3);

    // Both request bits: write wins.
    @(negedge CLK);
    dmemREN_EX_MEM = 1'b1;
    #1;
    checkOutput("both_dwen", {31'd0, dWEN}, 32'd1);
    checkOutput("both_dren", {31'd0, dREN}, 32'd0);

    // Flush during a two-cycle load stall.
    @(negedge CLK);
    applyStimulus();
    dmemREN_EX_MEM  = 1'b1;
    dmemaddr_EX_MEM = 32'h200;
    Rt_EX_MEM       = 5'd3;
    WEN_EX_MEM      = 1'b1;
    dmemload        = 32'h11111111;
    @(posedge CLK); #1;
    checkOutput("fl_bubble1", {31'd0, WEN_MEM_WB}, 32'd0);
    @(negedge CLK);
    flush_MEM_WB = 1'b1;
    #1;
    checkOutput("fl_dren", {31'd0, dREN}, 32'd1);
    checkOutput("fl_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge CLK); #1;
    checkOutput("fl_bubble2", {31'd0, WEN_MEM_WB}, 32'd0);
    @(negedge CLK);
    flush_MEM_WB = 1'b0;
    dhit         = 1'b1;
    @(posedge CLK); #1;
    checkOutput("fl_ld_wen", {31'd0, WEN_MEM_WB}, 32'd1);
    checkOutput("fl_ld_wsel", {27'd0, wsel_MEM_WB}, 32'd3);
    checkOutput("fl_ld_data", dmemload_MEM_WB, 32'h11111111);
    checkOutput("fl_stallcnt", stall_cycles, 32'd5);
    @(negedge CLK);
    applyStimulus();
    result_EX_MEM = 32'h77;
    WEN_EX_MEM    = 1'b1;
    flush_MEM_WB  = 1'b1;
    @(posedge CLK); #1;
    checkOutput("fl_alu_wen", {31'd0, WEN_MEM_WB}, 32'd0);
    checkOutput("fl_alu_result", result_MEM_WB, 32'd0);

    // Halt behind a pending load.
    @(negedge CLK);
    applyStimulus();
    dmemREN_EX_MEM = 1'b1;
    halt_EX_MEM    = 1'b1;
    WEN_EX_MEM     = 1'b1;
    Rt_EX_MEM      = 5'd9;
    result_EX_MEM  = 32'hABC;
    dmemload       = 32'hCAFEF00D;
    @(posedge CLK); #1;
    checkOutput("hl_pending_halt", {31'd0, halt_MEM_WB}, 32'd0);
    checkOutput("hl_stallcnt", stall_cycles, 32'd6);
    @(negedge CLK);
    dhit = 1'b1;
    @(posedge CLK); #1;
    checkOutput("hl_halt", {31'd0, halt_MEM_WB}, 32'd1);
    checkOutput("hl_data", dmemload_MEM_WB, 32'hCAFEF00D);
    checkOutput("hl_wsel", {27'd0, wsel_MEM_WB}, 32'd9);
    @(negedge CLK);
    applyStimulus();
    dmemREN_EX_MEM = 1'b1;
    result_EX_MEM  = 32'h999;
    #1;
    checkOutput("hl_dren", {31'd0, dREN}, 32'd0);
    checkOutput("hl_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    checkOutput("hl_hold_halt", {31'd0, halt_MEM_WB}, 32'd1);
    checkOutput("hl_hold_result", result_MEM_WB, 32'hABC);
    checkOutput("hl_hold_stallcnt", stall_cycles, 32'd6);

    // Reset leaves HALTED, then reset pulsed mid-WAIT.
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checkOutput("rh_halt", {31'd0, halt_MEM_WB}, 32'd0);
    checkOutput("rh_load", dmemload_MEM_WB, 32'd0);
    applyStimulus();
    @(negedge CLK);
    nRST = 1'b1;
    dmemREN_EX_MEM = 1'b1;
    Rt_EX_MEM      = 5'd4;
    WEN_EX_MEM     = 1'b1;
    dmemload       = 32'h4444;
    @(posedge CLK); #1;
    checkOutput("rw_stallcnt", stall_cycles, 32'd1);
    @(negedge CLK); #2;
    nRST = 1'b0;
    #1;
    checkOutput("rw_async_cnt", stall_cycles, 32'd0);
    checkOutput("rw_async_wen", {31'd0, WEN_MEM_WB}, 32'd0);
    dhit = 1'b1;
    @(posedge CLK); #1;
    checkOutput("rw_held_wen", {31'd0, WEN_MEM_WB}, 32'd0);
    checkOutput("rw_held_load", dmemload_MEM_WB, 32'd0);
    @(negedge CLK);
    applyStimulus();
    nRST            = 1'b1;
    result_EX_MEM   = 32'h5A;
    WEN_EX_MEM      = 1'b1;
    reg_dest_EX_MEM = 2'd3;
    Rd_EX_MEM       = 5'd7;
    #1;
    checkOutput("rw_idle_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge CLK); #1;
    checkOutput("rw_result", result_MEM_WB, 32'h5A);
    checkOutput("rw_wsel", {27'd0, wsel_MEM_WB}, 32'd7);
    checkOutput("rw_wen", {31'd0, WEN_MEM_WB}, 32'd1);
    checkOutput("rw_stallcnt_final", stall_cycles, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
